// File: rtl/imem_boot_loader_if.sv
// Byte-stream receive handshake plus instruction-memory write port of the boot loader.
// slave = loader side, master = stream source / memory side.
interface imem_boot_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: receives count/payload/checksum bytes, writes little-endian words to
// instruction memory and releases the CPU reset only after the XOR checksum matches.
module imem_boot_loader #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  logic                clk,
   input  logic                reset,
   imem_boot_loader_if.slave   bus,
   output logic                cpu_reset,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [ADDR_W:0]     words_loaded
);

   typedef enum logic [2:0] {HDR, LOAD, CHECK, DONE, ERR} state_t;

   state_t          state;
   logic [1:0]      byte_cnt;
   logic [31:0]     count;
   logic [31:0]     asm_word;
   logic [7:0]      csum;
   logic [ADDR_W:0] n_words;
   logic            busy_q;
   logic            done_q;
   logic            error_q;
   logic            cpu_reset_q;

   logic [31:0]     hdr_word;
   logic [31:0]     word_next;
   logic [ADDR_W:0] wl_next;
   logic            accept;

   assign hdr_word  = {bus.rx_data, count[31:8]};
   assign word_next = {bus.rx_data, asm_word[31:8]};
   assign wl_next   = words_loaded + (ADDR_W+1)'(1);
   assign accept    = bus.rx_valid & busy_q;

   // busy_q resets to 1 (HDR) so the loader is ready the first cycle reset is released;
   // gating with reset keeps busy/rx_ready low while reset is held.
   assign bus.rx_ready = busy_q & reset;
   assign busy         = busy_q & reset;
   assign done         = done_q;
   assign error        = error_q;
   assign cpu_reset    = cpu_reset_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= HDR;
         byte_cnt       <= '0;
         count          <= '0;
         asm_word       <= '0;
         csum           <= '0;
         n_words        <= '0;
         words_loaded   <= '0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         busy_q         <= 1'b1;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
         cpu_reset_q    <= 1'b1;
      end else begin
         bus.imem_we <= 1'b0;
         if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            unique case (state)
               HDR: begin
                  count <= hdr_word;
                  if (byte_cnt == 2'd3) begin
                     // Full 32-bit compare: high count bits must not alias into range.
                     if (hdr_word == '0 || hdr_word > 32'(MAX_WORDS)) begin
                        state   <= ERR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                     end else begin
                        state   <= LOAD;
                        n_words <= hdr_word[ADDR_W:0];
                     end
                  end
               end
               LOAD: begin
                  asm_word <= word_next;
                  csum     <= csum ^ bus.rx_data;
                  if (byte_cnt == 2'd3) begin
                     bus.imem_we    <= 1'b1;
                     bus.imem_addr  <= words_loaded[ADDR_W-1:0];
                     bus.imem_wdata <= word_next;
                     words_loaded   <= wl_next;
                     if (wl_next == n_words) begin
                        state <= CHECK;
                     end
                  end
               end
               CHECK: begin
                  busy_q <= 1'b0;
                  if (bus.rx_data == csum) begin
                     state       <= DONE;
                     done_q      <= 1'b1;
                     cpu_reset_q <= 1'b0;
                  end else begin
                     state   <= ERR;
                     error_q <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised self-checking bench: a byte-history model predicts every output each cycle,
// and literal expectations pin the directed scenarios.
module tb_imem_boot_loader;
   localparam int ADDR_W    = 8;
   localparam int MAX_WORDS = 256;

   logic            clk = 1'b0;
   logic            reset;
   logic            cpu_reset, busy, done, error;
   logic [ADDR_W:0] words_loaded;

   imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .cpu_reset    (cpu_reset),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the list of bytes accepted since reset fully determines the loader's outputs.
   logic [7:0]        got[$];
   logic [ADDR_W-1:0] m_addr;
   logic [31:0]       m_wdata;
   logic [31:0]       m_mem[256];
   logic [31:0]       dut_mem[256];
   int                wr_count = 0;
   logic [ADDR_W-1:0] last_addr;
   logic [31:0]       last_wdata;

   function automatic logic [31:0] hdr_n();
      return {got[3], got[2], got[1], got[0]};
   endfunction

   function automatic bit n_ok();
      if (got.size() < 4) return 1'b0;
      return hdr_n() != 0 && hdr_n() <= MAX_WORDS;
   endfunction

   // 0 header, 1 payload, 2 checksum, 3 done, 4 error
   function automatic int phase();
      int unsigned n;
      logic [7:0]  x;
      if (got.size() < 4) return 0;
      if (!n_ok()) return 4;
      n = hdr_n();
      if (got.size() < 4 + 4*n) return 1;
      if (got.size() == 4 + 4*n) return 2;
      x = '0;
      for (int unsigned i = 4; i < 4 + 4*n; i++) x ^= got[i];
      return (got[4 + 4*n] == x) ? 3 : 4;
   endfunction

   function automatic int unsigned exp_words();
      int unsigned k;
      if (!n_ok()) return 0;
      k = (got.size() - 4) / 4;
      return (k < hdr_n()) ? k : hdr_n();
   endfunction

   always @(posedge clk) begin
      int          ph;
      int unsigned i;
      bit          we;
      bit          rdy;
      ph = phase();
      we = 1'b0;
      if (!reset) begin
         got.delete();
         m_addr  = '0;
         m_wdata = '0;
      end else if (bus.rx_valid && ph < 3) begin
         got.push_back(bus.rx_data);
         i = got.size() - 1;
         if (i >= 4 && n_ok() && ((i - 4) % 4) == 3 && i < 4 + 4*hdr_n()) begin
            we      = 1'b1;
            m_addr  = ADDR_W'((i - 4) / 4);
            m_wdata = {got[i], got[i-1], got[i-2], got[i-3]};
            m_mem[m_addr] = m_wdata;
         end
      end
      #1;
      ph  = phase();
      rdy = reset && ph < 3;
      chk("rx_ready",     32'(bus.rx_ready),  32'(rdy));
      chk("busy",         32'(busy),          32'(rdy));
      chk("done",         32'(done),          32'(ph == 3));
      chk("error",        32'(error),         32'(ph == 4));
      chk("cpu_reset",    32'(cpu_reset),     32'(ph != 3));
      chk("imem_we",      32'(bus.imem_we),   32'(we));
      chk("imem_addr",    32'(bus.imem_addr), 32'(m_addr));
      chk("imem_wdata",   bus.imem_wdata,     m_wdata);
      chk("words_loaded", 32'(words_loaded),  exp_words());
      if (bus.imem_we === 1'b1) begin
         wr_count++;
         dut_mem[bus.imem_addr] = bus.imem_wdata;
         last_addr  = bus.imem_addr;
         last_wdata = bus.imem_wdata;
      end
   end

   logic [7:0] stream[$];
   logic [7:0] sxor;

   task automatic new_stream();
      stream.delete();
      sxor = '0;
   endtask

   task automatic push_word(input logic [31:0] w, input bit payload);
      for (int b = 0; b < 4; b++) begin
         stream.push_back(w[8*b +: 8]);
         if (payload) sxor ^= w[8*b +: 8];
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.rx_valid = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned maxgap);
      int unsigned g;
      g = (maxgap == 0) ? 0 : $urandom_range(maxgap, 0);
      repeat (g) begin
         @(negedge clk);
         bus.rx_valid = 1'b0;
         bus.rx_data  = 8'($urandom);
      end
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
   endtask

   task automatic send_stream(input int unsigned maxgap);
      foreach (stream[i]) send_byte(stream[i], maxgap);
      idle(3);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset        = 1'b0;
      bus.rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic build_s1(input logic [7:0] csum);
      new_stream();
      push_word(32'd2, 1'b0);
      push_word(32'h00500093, 1'b1);
      push_word(32'h00A00113, 1'b1);
      stream.push_back(csum);
   endtask

   int          base;
   int unsigned n;
   bit          good;

   initial begin
      reset        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_rx_ready",  32'(bus.rx_ready),  0);
      chk("rst_cpu_reset", 32'(cpu_reset),     1);
      chk("rst_busy",      32'(busy),          0);
      chk("rst_words",     32'(words_loaded),  0);
      chk("rst_addr",      32'(bus.imem_addr), 0);
      reset = 1'b1;

      // Two-word image with the correct checksum
      build_s1(8'h71);
      base = wr_count;
      send_stream(0);
      chk("s1_writes",    32'(wr_count - base), 2);
      chk("s1_done",      32'(done),            1);
      chk("s1_cpu_reset", 32'(cpu_reset),       0);
      chk("s1_words",     32'(words_loaded),    2);
      chk("s1_mem0",      dut_mem[0],           32'h00500093);
      chk("s1_mem1",      dut_mem[1],           32'h00A00113);
      chk("model_mem0",   m_mem[0],             32'h00500093);
      chk("model_sxor",   32'(sxor),            32'h71);
      // Further bytes after DONE are ignored
      new_stream();
      push_word(32'hDEADBEEF, 1'b0);
      send_stream(0);
      chk("s1_post_done", 32'(done), 1);

      // Wrong checksum
      do_reset();
      build_s1(8'h70);
      base = wr_count;
      send_stream(0);
      chk("s2_writes",    32'(wr_count - base), 2);
      chk("s2_error",     32'(error),           1);
      chk("s2_done",      32'(done),            0);
      chk("s2_cpu_reset", 32'(cpu_reset),       1);
      chk("s2_rx_ready",  32'(bus.rx_ready),    0);

      // Zero count, count above MAX_WORDS, count with high bits set
      do_reset();
      new_stream();
      push_word(32'd0, 1'b0);
      push_word(32'h11223344, 1'b0);
      base = wr_count;
      send_stream(0);
      chk("s3_error",  32'(error),           1);
      chk("s3_writes", 32'(wr_count - base), 0);
      chk("s3_words",  32'(words_loaded),    0);

      do_reset();
      new_stream();
      push_word(32'd257, 1'b0);
      push_word(32'h11223344, 1'b0);
      base = wr_count;
      send_stream(1);
      chk("s4_error",  32'(error),           1);
      chk("s4_writes", 32'(wr_count - base), 0);

      do_reset();
      new_stream();
      push_word(32'h00010001, 1'b0);
      push_word(32'h11223344, 1'b0);
      base = wr_count;
      send_stream(0);
      chk("s4b_error",  32'(error),           1);
      chk("s4b_writes", 32'(wr_count - base), 0);

      // Reset in the middle of the second word, then a full reload
      do_reset();
      new_stream();
      push_word(32'd2, 1'b0);
      push_word(32'h00500093, 1'b1);
      stream.push_back(8'h13);
      stream.push_back(8'h01);
      base = wr_count;
      foreach (stream[i]) send_byte(stream[i], 3);
      idle(2);
      chk("s5_partial_writes", 32'(wr_count - base), 1);
      @(negedge clk);
      reset        = 1'b0;
      bus.rx_valid = 1'b0;
      @(negedge clk);
      chk("s5_rst_busy",  32'(busy),           0);
      chk("s5_rst_rdy",   32'(bus.rx_ready),   0);
      chk("s5_rst_words", 32'(words_loaded),   0);
      chk("s5_rst_wdata", bus.imem_wdata,      0);
      chk("s5_rst_cpu",   32'(cpu_reset),      1);
      reset = 1'b1;
      #1;
      chk("s5_hdr_busy",  32'(busy), 1);
      chk("s5_writes_after_rst", 32'(wr_count - base), 1);
      build_s1(8'h71);
      send_stream(3);
      chk("s5_reload_done", 32'(done), 1);
      chk("s5_mem1",        dut_mem[1], 32'h00A00113);

      // Full-size image
      do_reset();
      new_stream();
      push_word(32'(MAX_WORDS), 1'b0);
      for (int w = 0; w < MAX_WORDS; w++) push_word(32'(w), 1'b1);
      stream.push_back(sxor);
      base = wr_count;
      send_stream(0);
      chk("s6_writes",     32'(wr_count - base), 256);
      chk("s6_last_addr",  32'(last_addr),       32'hFF);
      chk("s6_last_wdata", last_wdata,           32'h000000FF);
      chk("s6_words",      32'(words_loaded),    256);
      chk("s6_done",       32'(done),            1);

      // Random images with random gaps and random checksum corruption
      for (int r = 0; r < 8; r++) begin
         do_reset();
         new_stream();
         n    = $urandom_range(6, 1);
         good = 1'($urandom_range(1, 0));
         push_word(n, 1'b0);
         for (int unsigned w = 0; w < n; w++) push_word($urandom, 1'b1);
         stream.push_back(good ? sxor : (sxor ^ 8'($urandom_range(255, 1))));
         push_word($urandom, 1'b0);
         base = wr_count;
         send_stream(2);
         chk("rnd_done",   32'(done),            32'(good));
         chk("rnd_error",  32'(error),           32'(!good));
         chk("rnd_words",  32'(words_loaded),    n);
         chk("rnd_writes", 32'(wr_count - base), n);
      end

      do_reset();
      new_stream();
      push_word($urandom_range(32'hFFFF_FFFF, 257), 1'b0);
      push_word($urandom, 1'b0);
      base = wr_count;
      send_stream(2);
      chk("rnd_big_hdr_error",  32'(error),           1);
      chk("rnd_big_hdr_writes", 32'(wr_count - base), 0);

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
